// File: rtl/memory_load_scheduler_if.sv
// Bus bundle between the load issue stage, data memory and memory_receive.
// master: scheduler side; slave: requesters/memory/receive side.
interface memory_load_scheduler_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int LOG2_NUM_BYTES = 2
);
  logic                      req0_valid;
  logic [ADDRESS_BITS-1:0]   req0_address;
  logic [LOG2_NUM_BYTES-1:0] req0_log2_bytes;
  logic                      req0_unsigned;
  logic                      req0_ready;
  logic                      req1_valid;
  logic [ADDRESS_BITS-1:0]   req1_address;
  logic [LOG2_NUM_BYTES-1:0] req1_log2_bytes;
  logic                      req1_unsigned;
  logic                      req1_ready;
  logic                      mem_read;
  logic [ADDRESS_BITS-1:0]   mem_address;
  logic                      mem_ready;
  logic                      mem_valid;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      rx_valid;
  logic                      rx_id;
  logic [LOG2_NUM_BYTES-1:0] rx_log2_bytes;
  logic                      rx_unsigned_load;
  logic [DATA_WIDTH-1:0]     rx_address;
  logic [DATA_WIDTH-1:0]     rx_memory_data;
  logic                      rx_error;

  modport master (
    input  req0_valid, req0_address, req0_log2_bytes, req0_unsigned,
    input  req1_valid, req1_address, req1_log2_bytes, req1_unsigned,
    output req0_ready, req1_ready,
    output mem_read, mem_address,
    input  mem_ready, mem_valid, mem_data,
    output rx_valid, rx_id, rx_log2_bytes, rx_unsigned_load, rx_address, rx_memory_data, rx_error
  );

  modport slave (
    output req0_valid, req0_address, req0_log2_bytes, req0_unsigned,
    output req1_valid, req1_address, req1_log2_bytes, req1_unsigned,
    input  req0_ready, req1_ready,
    input  mem_read, mem_address,
    output mem_ready, mem_valid, mem_data,
    input  rx_valid, rx_id, rx_log2_bytes, rx_unsigned_load, rx_address, rx_memory_data, rx_error
  );
endinterface

// File: rtl/memory_load_scheduler.sv
// Round-robin arbiter sharing one memory read port between two load requesters, one load in flight.
// Optional WAIT timeout with error response is enabled by defining MEM_SCHED_TIMEOUT_EN.
module memory_load_scheduler #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                     clock,
  input logic                     reset,
  memory_load_scheduler_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                    state, state_next;
  logic                      last_grant;
  logic                      grant_id;
  logic                      accept;
  logic                      resp_load;
  logic [ADDRESS_BITS-1:0]   cap_address;
  logic [LOG2_NUM_BYTES-1:0] cap_log2_bytes;
  logic                      cap_unsigned;
  logic                      cap_id;
  logic                      rx_id_q;
  logic [LOG2_NUM_BYTES-1:0] rx_log2_bytes_q;
  logic                      rx_unsigned_q;
  logic [DATA_WIDTH-1:0]     rx_address_q;
  logic [DATA_WIDTH-1:0]     rx_data_q;

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] timeout_count;
  logic             rx_error_q;
`endif

  // Tie goes to the requester not served last; accept is suppressed while reset is asserted
  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant_id = ~last_grant;
    accept = reset && (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      S_ISSUE: if (bus.mem_ready) state_next = S_WAIT;
      S_WAIT: begin
        if (bus.mem_valid)
          state_next = S_RESP;
`ifdef MEM_SCHED_TIMEOUT_EN
        else if (timeout_count == CNT_W'(TIMEOUT_CYCLES))
          state_next = S_RESP;
`endif
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign resp_load = (state == S_WAIT) && (state_next == S_RESP);

  always_comb begin
    bus.req0_ready       = accept && !grant_id;
    bus.req1_ready       = accept && grant_id;
    bus.mem_read         = (state == S_ISSUE);
    bus.mem_address      = (state == S_ISSUE) ? cap_address : '0;
    bus.rx_valid         = (state == S_RESP);
    bus.rx_id            = rx_id_q;
    bus.rx_log2_bytes    = rx_log2_bytes_q;
    bus.rx_unsigned_load = rx_unsigned_q;
    bus.rx_address       = rx_address_q;
    bus.rx_memory_data   = rx_data_q;
`ifdef MEM_SCHED_TIMEOUT_EN
    bus.rx_error         = rx_error_q && (state == S_RESP);
`else
    bus.rx_error         = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= grant_id;
  end

  // Request attributes are only meaningful after an accept, so they carry no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      cap_id         <= grant_id;
      cap_address    <= grant_id ? bus.req1_address    : bus.req0_address;
      cap_log2_bytes <= grant_id ? bus.req1_log2_bytes : bus.req0_log2_bytes;
      cap_unsigned   <= grant_id ? bus.req1_unsigned   : bus.req0_unsigned;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_id_q         <= 1'b0;
      rx_log2_bytes_q <= '0;
      rx_unsigned_q   <= 1'b0;
      rx_address_q    <= '0;
      rx_data_q       <= '0;
`ifdef MEM_SCHED_TIMEOUT_EN
      rx_error_q      <= 1'b0;
`endif
    end else if (resp_load) begin
      rx_id_q         <= cap_id;
      rx_log2_bytes_q <= cap_log2_bytes;
      rx_unsigned_q   <= cap_unsigned;
      rx_address_q    <= {{(DATA_WIDTH - ADDRESS_BITS){1'b0}}, cap_address};
`ifdef MEM_SCHED_TIMEOUT_EN
      rx_data_q       <= bus.mem_valid ? bus.mem_data : '0;
      rx_error_q      <= !bus.mem_valid;
`else
      rx_data_q       <= bus.mem_data;
`endif
    end
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  // A same-cycle mem_valid beats the timeout because the counter is only compared without it
  always_ff @(posedge clock) begin
    if (!reset)
      timeout_count <= '0;
    else if ((state == S_ISSUE) && bus.mem_ready)
      timeout_count <= '0;
    else if ((state == S_WAIT) && !bus.mem_valid)
      timeout_count <= timeout_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_memory_load_scheduler.sv
// Directed bench for memory_load_scheduler: expected responses are queued at accept time and
// compared by a monitor whenever rx_valid pulses.
module tb_memory_load_scheduler;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int LW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memory_load_scheduler_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .LOG2_NUM_BYTES(LW)) bus();

  memory_load_scheduler #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  typedef struct {
    logic          id;
    logic [LW-1:0] log2;
    logic          uns;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    #2;
    if (bus.rx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rx_unexpected", 64'(bus.rx_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_id",            64'(bus.rx_id),            64'(e.id));
        check("rx_log2_bytes",    64'(bus.rx_log2_bytes),    64'(e.log2));
        check("rx_unsigned_load", 64'(bus.rx_unsigned_load), 64'(e.uns));
        check("rx_address",       64'(bus.rx_address),       64'(e.addr));
        check("rx_memory_data",   64'(bus.rx_memory_data),   64'(e.data));
        check("rx_error",         64'(bus.rx_error),         64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int n, input logic v, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input logic u);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_address = a; bus.req0_log2_bytes = l; bus.req0_unsigned = u;
    end else begin
      bus.req1_valid = v; bus.req1_address = a; bus.req1_log2_bytes = l; bus.req1_unsigned = u;
    end
  endtask

  // Entered at a negedge right after requests are driven; returns at the negedge of the next IDLE cycle
  task automatic run_load(input logic exp_id, input logic [DW-1:0] data, input int stall, input bit hold);
    exp_t e;
    logic [AW-1:0] a;
    #2;
    check("req0_ready_accept", 64'(bus.req0_ready), 64'(!exp_id));
    check("req1_ready_accept", 64'(bus.req1_ready), 64'(exp_id));
    a      = exp_id ? bus.req1_address : bus.req0_address;
    e.id   = exp_id;
    e.log2 = exp_id ? bus.req1_log2_bytes : bus.req0_log2_bytes;
    e.uns  = exp_id ? bus.req1_unsigned : bus.req0_unsigned;
    e.addr = {{(DW - AW){1'b0}}, a};
    e.data = data;
    e.err  = 1'b0;
    sb.push_back(e);
    @(negedge clock);
    if (!hold) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    bus.mem_ready = (stall == 0);
    #2;
    check("mem_read_issue", 64'(bus.mem_read), 64'd1);
    check("mem_address_issue", 64'(bus.mem_address), 64'(a));
    check("ready_busy_issue", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    for (int k = 1; k <= stall; k++) begin
      @(negedge clock);
      bus.mem_ready = (k == stall);
      #2;
      check("mem_read_stall", 64'(bus.mem_read), 64'd1);
      check("mem_address_stall", 64'(bus.mem_address), 64'(a));
      check("ready_busy_stall", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    end
    @(negedge clock);
    bus.mem_valid = 1'b1;
    bus.mem_data  = data;
    #2;
    check("mem_read_wait", 64'(bus.mem_read), 64'd0);
    @(negedge clock);
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    #2;
    check("rx_valid_latency", 64'(bus.rx_valid), 64'd1);
    check("ready_busy_resp", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_mem_read"},    64'(bus.mem_read),         64'd0);
    check({tag, "_mem_address"}, 64'(bus.mem_address),      64'd0);
    check({tag, "_rx_valid"},    64'(bus.rx_valid),         64'd0);
    check({tag, "_rx_id"},       64'(bus.rx_id),            64'd0);
    check({tag, "_rx_log2"},     64'(bus.rx_log2_bytes),    64'd0);
    check({tag, "_rx_uns"},      64'(bus.rx_unsigned_load), 64'd0);
    check({tag, "_rx_address"},  64'(bus.rx_address),       64'd0);
    check({tag, "_rx_data"},     64'(bus.rx_memory_data),   64'd0);
    check({tag, "_rx_error"},    64'(bus.rx_error),         64'd0);
    check({tag, "_ready"},       64'({bus.req0_ready, bus.req1_ready}), 64'd0);
  endtask

  initial begin
    bit seen;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;

    // Reset state
    repeat (2) @(negedge clock);
    #2;
    check_cleared("reset");
    @(negedge clock);
    reset = 1'b1;

    // Single minimum-latency load from req0
    set_req(0, 1'b1, 20'h00104, 2'd2, 1'b0);
    run_load(1'b0, 32'hDEADBEEF, 0, 1'b0);
    #2;
    check("rx_valid_one_cycle", 64'(bus.rx_valid), 64'd0);
    check("rx_data_hold", 64'(bus.rx_memory_data), 64'hDEADBEEF);
    check("rx_address_hold", 64'(bus.rx_address), 64'h00000104);
    check("mem_read_idle", 64'(bus.mem_read), 64'd0);

    // Round-robin from reset with both requesters held valid
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    set_req(0, 1'b1, 20'h00200, 2'd0, 1'b1);
    set_req(1, 1'b1, 20'hFFFFC, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++)
      run_load(logic'(i % 2), 32'h1000_0000 + 32'(i), 0, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // mem_ready held low for 5 ISSUE cycles
    @(negedge clock);
    set_req(1, 1'b1, 20'h12345, 2'd2, 1'b1);
    run_load(1'b1, 32'hCAFEF00D, 5, 1'b0);

    // Reset while in WAIT; the late mem_valid must be dropped
    set_req(0, 1'b1, 20'h00ABC, 2'd1, 1'b0);
    #2;
    check("req0_ready_abandon", 64'(bus.req0_ready), 64'd1);
    @(negedge clock);
    bus.req0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("mem_read_wait_pre_reset", 64'(bus.mem_read), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'h5555_5555;
    #2;
    check_cleared("midreset");
    @(negedge clock);
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    #2;
    check("rx_valid_late_drop", 64'(bus.rx_valid), 64'd0);
    @(negedge clock);
    set_req(1, 1'b1, 20'h00010, 2'd0, 1'b1);
    run_load(1'b1, 32'h0000_0077, 0, 1'b0);

    // Memory never answers
    set_req(0, 1'b1, 20'h00300, 2'd2, 1'b0);
    #2;
    check("req0_ready_timeout", 64'(bus.req0_ready), 64'd1);
`ifdef MEM_SCHED_TIMEOUT_EN
    begin
      exp_t e;
      e.id = 1'b0; e.log2 = 2'd2; e.uns = 1'b0; e.addr = 32'h00000300; e.data = '0; e.err = 1'b1;
      sb.push_back(e);
    end
`endif
    @(negedge clock);
    bus.req0_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      #2;
      if (bus.rx_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
`ifdef MEM_SCHED_TIMEOUT_EN
    check("timeout_response", 64'(seen), 64'd1);
    @(negedge clock);
`else
    check("wait_holds_no_rx", 64'(seen), 64'd0);
    check("wait_mem_read_low", 64'(bus.mem_read), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #2;
    check("recover_rx_valid", 64'(bus.rx_valid), 64'd0);
`endif

    @(negedge clock);
    #3;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
